// File: rtl/xalu_md_unit_if.sv
// rtl/xalu_md_unit_if.sv - Execute-stage bus between decoder/hazard logic and the mul/div unit
interface xalu_md_unit_if;
  logic        en;
  logic [3:0]  XALUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        start;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] XALU_out;

  modport master (
    output en, XALUOp, A, B,
    input  busy, start, HI, LO, XALU_out
  );

  modport slave (
    input  en, XALUOp, A, B,
    output busy, start, HI, LO, XALU_out
  );
endinterface

// File: rtl/xalu_md_unit.sv
// rtl/xalu_md_unit.sv - HI/LO owner with multi-cycle mult/div; optional madd/maddu via XALU_MADD_EN
module xalu_md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset_n,
  xalu_md_unit_if.slave io
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic              pend_valid_q, pend_valid_d;

  // Op decode
  logic op_mul_s, op_mul_u, op_div_s, op_div_u, op_madd_s, op_madd_u;
  logic is_mul, is_div, busy, start;

  assign op_mul_s = (io.XALUOp == 4'd1);
  assign op_mul_u = (io.XALUOp == 4'd2);
  assign op_div_s = (io.XALUOp == 4'd7);
  assign op_div_u = (io.XALUOp == 4'd8);
`ifdef XALU_MADD_EN
  assign op_madd_s = (io.XALUOp == 4'd9);
  assign op_madd_u = (io.XALUOp == 4'd10);
`else
  assign op_madd_s = 1'b0;
  assign op_madd_u = 1'b0;
`endif

  assign is_mul = op_mul_s | op_mul_u | op_madd_s | op_madd_u;
  assign is_div = op_div_s | op_div_u;
  assign busy   = (state_q == ST_BUSY);
  assign start  = io.en & (is_mul | is_div) & ~busy;

  // Multiply: low 64 bits of the sign-extended product equal the signed product
  logic [63:0] prod_s, prod_u, prod, mul_res;
  assign prod_s  = {{32{io.A[31]}}, io.A} * {{32{io.B[31]}}, io.B};
  assign prod_u  = {32'b0, io.A} * {32'b0, io.B};
  assign prod    = (op_mul_s | op_madd_s) ? prod_s : prod_u;
  assign mul_res = (op_madd_s | op_madd_u) ? ({hi_q, lo_q} + prod) : prod;

  // Divide: a divisor of 1 stands in for zero (result discarded) and for
  // INT_MIN / -1, where dividing by 1 yields exactly quotient INT_MIN, remainder 0
  logic        div_zero, div_ovf;
  logic [31:0] b_div_s, b_div_u;
  logic signed [31:0] q_s, r_s;
  logic [31:0] q_u, r_u, div_q, div_r;
  assign div_zero = (io.B == 32'd0);
  assign div_ovf  = (io.A == 32'h8000_0000) && (io.B == 32'hFFFF_FFFF);
  assign b_div_s  = (div_zero | div_ovf) ? 32'd1 : io.B;
  assign b_div_u  = div_zero ? 32'd1 : io.B;
  assign q_s      = $signed(io.A) / $signed(b_div_s);
  assign r_s      = $signed(io.A) % $signed(b_div_s);
  assign q_u      = io.A / b_div_u;
  assign r_u      = io.A % b_div_u;
  assign div_q    = op_div_s ? q_s : q_u;
  assign div_r    = op_div_s ? r_s : r_u;

  // Next-state: countdown/commit while busy, otherwise start or mthi/mtlo
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    pend_valid_d = pend_valid_q;
    case (state_q)
      ST_BUSY: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (pend_valid_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        if (start) begin
          state_d = ST_BUSY;
          if (is_mul) begin
            cnt_d        = MULT_LOAD;
            pend_hi_d    = mul_res[63:32];
            pend_lo_d    = mul_res[31:0];
            pend_valid_d = 1'b1;
          end else begin
            cnt_d        = DIV_LOAD;
            pend_hi_d    = div_r;
            pend_lo_d    = div_q;
            pend_valid_d = ~div_zero;
          end
        end else if (io.en && io.XALUOp == 4'd3) begin
          hi_d = io.A;
        end else if (io.en && io.XALUOp == 4'd4) begin
          lo_d = io.A;
        end
      end
    endcase
  end

  // State registers; reset discards any in-flight result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      pend_hi_q    <= '0;
      pend_lo_q    <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      pend_hi_q    <= pend_hi_d;
      pend_lo_q    <= pend_lo_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign io.busy     = busy;
  assign io.start    = start;
  assign io.HI       = hi_q;
  assign io.LO       = lo_q;
  assign io.XALU_out = (io.XALUOp == 4'd5) ? hi_q :
                       (io.XALUOp == 4'd6) ? lo_q : 32'd0;

endmodule

// File: tb/tb_xalu_md_unit.sv
// tb/tb_xalu_md_unit.sv - directed self-checking bench for xalu_md_unit
module tb_xalu_md_unit;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  xalu_md_unit_if bus ();

  xalu_md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one op for one edge; st reports the combinational start seen before the edge
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic st);
    @(negedge clk);
    bus.en = 1'b1; bus.XALUOp = op; bus.A = a; bus.B = b;
    #1 st = bus.start;
    @(posedge clk);
    #1;
    bus.en = 1'b0; bus.XALUOp = 4'd0;
  endtask

  // Count cycles busy stays high, bounded
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 100) begin
      cycles++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic st;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.busy, bus.HI, bus.LO} !== 65'd0) begin
      n_errors++;
      $display("FAIL reset_state: busy/HI/LO=%h expected 0", {bus.busy, bus.HI, bus.LO});
    end
    @(negedge clk); reset_n = 1'b1;
    issue(4'd1, 32'hFFFF_FFFE, 32'd3, st);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_async_busy: got %b expected 0", bus.busy);
    end
    @(negedge clk); reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.busy, bus.HI, bus.LO} !== 65'd0) begin
      n_errors++;
      $display("FAIL reset_no_commit: busy/HI/LO=%h expected 0", {bus.busy, bus.HI, bus.LO});
    end
  endtask

  task automatic test_mult();
    logic st;
    int cyc;
    issue(4'd1, 32'hFFFF_FFFE, 32'd3, st);
    n_checks++;
    if (st !== 1'b1) begin n_errors++; $display("FAIL mult_start: got %b expected 1", st); end
    wait_idle(cyc);
    n_checks++;
    if (cyc !== 5) begin n_errors++; $display("FAIL mult_busy_cycles: got %0d expected 5", cyc); end
    n_checks++;
    if ({bus.HI, bus.LO} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      n_errors++; $display("FAIL mult_result: got %h expected FFFFFFFFFFFFFFFA", {bus.HI, bus.LO});
    end
    issue(4'd2, 32'hFFFF_FFFE, 32'd3, st);
    wait_idle(cyc);
    n_checks++;
    if ({bus.HI, bus.LO} !== 64'h0000_0002_FFFF_FFFA) begin
      n_errors++; $display("FAIL multu_result: got %h expected 00000002FFFFFFFA", {bus.HI, bus.LO});
    end
  endtask

  task automatic test_div();
    logic st;
    int cyc;
    issue(4'd7, 32'hFFFF_FFF9, 32'd2, st);
    wait_idle(cyc);
    n_checks++;
    if (cyc !== 10) begin n_errors++; $display("FAIL div_busy_cycles: got %0d expected 10", cyc); end
    n_checks++;
    if ({bus.HI, bus.LO} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      n_errors++; $display("FAIL div_result: got %h expected FFFFFFFFFFFFFFFD", {bus.HI, bus.LO});
    end
    issue(4'd8, 32'd7, 32'd2, st);
    wait_idle(cyc);
    n_checks++;
    if ({bus.HI, bus.LO} !== 64'h0000_0001_0000_0003) begin
      n_errors++; $display("FAIL divu_result: got %h expected 0000000100000003", {bus.HI, bus.LO});
    end
    issue(4'd7, 32'h8000_0000, 32'hFFFF_FFFF, st);
    wait_idle(cyc);
    n_checks++;
    if ({bus.HI, bus.LO} !== 64'h0000_0000_8000_0000) begin
      n_errors++; $display("FAIL div_overflow: got %h expected 0000000080000000", {bus.HI, bus.LO});
    end
  endtask

  task automatic test_div_zero();
    logic st;
    int cyc;
    issue(4'd3, 32'h11, 32'd0, st);
    issue(4'd4, 32'h22, 32'd0, st);
    issue(4'd7, 32'd5, 32'd0, st);
    wait_idle(cyc);
    n_checks++;
    if (cyc !== 10) begin n_errors++; $display("FAIL divzero_busy_cycles: got %0d expected 10", cyc); end
    n_checks++;
    if ({bus.HI, bus.LO} !== 64'h0000_0011_0000_0022) begin
      n_errors++; $display("FAIL divzero_hold: got %h expected 0000001100000022", {bus.HI, bus.LO});
    end
  endtask

  task automatic test_move();
    logic st;
    int cyc;
    issue(4'd3, 32'hDEAD_BEEF, 32'd0, st);
    n_checks++;
    if (bus.HI !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL mthi: got %h expected DEADBEEF", bus.HI); end
    bus.XALUOp = 4'd5;
    #1;
    n_checks++;
    if (bus.XALU_out !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL mfhi: got %h expected DEADBEEF", bus.XALU_out); end
    bus.XALUOp = 4'd6;
    #1;
    n_checks++;
    if (bus.XALU_out !== 32'h22) begin n_errors++; $display("FAIL mflo: got %h expected 00000022", bus.XALU_out); end
    bus.XALUOp = 4'd9;
    bus.en = 1'b1;
    #1;
    n_checks++;
    if ({bus.start, bus.XALU_out} !== 33'd0) begin
      n_errors++; $display("FAIL unknown_op: start/out=%h expected 0", {bus.start, bus.XALU_out});
    end
    bus.en = 1'b0; bus.XALUOp = 4'd0;
    issue(4'd1, 32'd2, 32'd3, st);
    issue(4'd4, 32'h1234_5678, 32'd0, st);
    n_checks++;
    if (bus.LO !== 32'h22) begin n_errors++; $display("FAIL mtlo_busy: got %h expected 00000022", bus.LO); end
    wait_idle(cyc);
    n_checks++;
    if ({bus.HI, bus.LO} !== 64'h0000_0000_0000_0006) begin
      n_errors++; $display("FAIL mult_after_mtlo: got %h expected 0000000000000006", {bus.HI, bus.LO});
    end
  endtask

  task automatic test_back_to_back();
    logic st;
    logic start_seen;
    int cyc;
    issue(4'd1, 32'd5, 32'd7, st);
    bus.en = 1'b1; bus.XALUOp = 4'd1; bus.A = 32'd100; bus.B = 32'd100;
    start_seen = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      start_seen = start_seen | bus.start;
      cyc++;
      @(posedge clk);
      #1;
    end
    bus.en = 1'b0; bus.XALUOp = 4'd0;
    n_checks++;
    if (start_seen !== 1'b0) begin n_errors++; $display("FAIL b2b_start: got %b expected 0", start_seen); end
    n_checks++;
    if (cyc !== 5) begin n_errors++; $display("FAIL b2b_busy_cycles: got %0d expected 5", cyc); end
    n_checks++;
    if ({bus.HI, bus.LO} !== 64'h0000_0000_0000_0023) begin
      n_errors++; $display("FAIL b2b_result: got %h expected 0000000000000023", {bus.HI, bus.LO});
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.busy, bus.LO} !== 33'h0_0000_0023) begin
      n_errors++; $display("FAIL b2b_ignored: busy/LO=%h expected 000000023", {bus.busy, bus.LO});
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.en = 1'b0; bus.XALUOp = 4'd0; bus.A = 32'd0; bus.B = 32'd0;
    reset_n = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_move();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/xalu_md_unit.md
Name: xalu_md_unit

Overview:
- Multiply/divide unit in the Execute stage. It consumes the 4-bit XALUOp code that the instruction decoder produces.
- Owns the HI/LO registers. Runs mult/multu/div/divu as multi-cycle operations and performs mthi/mtlo writes.
- Exposes HI or LO for mfhi/mflo, plus a busy flag that the hazard unit uses to stall later HI/LO-touching instructions.

Parameters:
- MULT_CYCLES, 5: cycles busy is held for mult/multu (min 1).
- DIV_CYCLES, 10: cycles busy is held for div/divu (min 1).

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  instruction in E is valid and not flushed/stalled; qualifies XALUOp
- XALUOp  in  4  1 mult, 2 multu, 3 mthi, 4 mtlo, 5 mfhi, 6 mflo, 7 div, 8 divu; others are no-op
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- busy  out  1  a multi-cycle operation is in flight
- start  out  1  combinational: en & XALUOp in {1,2,7,8} & !busy
- HI  out  32  HI register
- LO  out  32  LO register
- XALU_out  out  32  combinational: HI when XALUOp==5, LO when XALUOp==6, else 0

Behaviour:
- Reset (async, reset_n low): HI=0, LO=0, busy=0, counter=0, pending result=0. Takes effect immediately, including mid-operation; any in-flight result is discarded.
- Start of an operation:
  - On the edge where start=1, latch the full 64-bit result into pend_hi/pend_lo.
  - Load the counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 7,8). Set busy=1.
- Operation results:
  - mult: signed 32x32 to 64 bits; pend_hi=upper 32, pend_lo=lower 32.
  - multu: same, unsigned.
  - div: pend_lo=quotient truncated toward zero, pend_hi=remainder with the sign of A.
  - divu: same, unsigned.
  - A=0x80000000, B=-1 (signed): quotient 0x80000000, remainder 0.
- Divide by zero (B==0, op 7 or 8): busy still runs the full DIV_CYCLES. HI/LO stay unchanged at commit (a pend_valid flag is cleared).
- Counting and commit:
  - While busy, the counter decrements each edge.
  - On the edge where counter==1: busy goes to 0, counter goes to 0, and HI/LO take the pending values.
  - busy is therefore high for exactly N cycles after the start edge. New HI/LO are visible in the cycle busy first reads 0.
- mthi/mtlo (ops 3/4): when en=1 and busy=0, HI<=A (op 3) or LO<=A (op 4) on the edge.
- Ops 1–4 and 7–8 arriving while busy=1 are ignored, with no side effects. The hazard unit stalls on (busy|start) for ops 1–8, so this case is protection only.
- mfhi/mflo: XALU_out is combinational and reads the current HI/LO. No bypass of pending results, because the stall guarantees commit happens first.
- en=0: no state change except the counter progressing.
- Unknown op codes (0, 9–15): no state change; XALU_out=0.

Optional Feature:
- Macro: XALU_MADD_EN.
- When defined:
  - Op 9 (madd) and op 10 (maddu) are accepted with MULT_CYCLES latency.
  - At start, the pending result is {HI,LO} + A*B (signed for madd, unsigned for maddu). The sum wraps modulo 2^64.
  - start also covers ops 9 and 10.
- When undefined: ops 9/10 behave as unknown op codes.

Test Plan:
- Reset: drive reset_n low mid-mult (counter=3), release -> HI=0, LO=0, busy=0 immediately; no commit occurs later.
- mult: A=0xFFFFFFFE (-2), B=3, en=1 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Repeat as multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div: A=-7, B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with A=7, B=2 -> LO=3, HI=1.
- Divide by zero: HI=0x11, LO=0x22, div A=5, B=0 -> busy 10 cycles, HI/LO remain 0x11/0x22.
- mthi/mtlo/mfhi/mflo:
  - mthi A=0xDEADBEEF -> next cycle HI=0xDEADBEEF, and op 5 gives XALU_out=0xDEADBEEF.
  - mtlo issued while busy=1 -> LO unchanged.
- Back-to-back: mult issued while a previous mult is busy -> second op is ignored; start=0 throughout busy; HI/LO hold the first result.
